// File: rtl/e203_ifu_instr_aligner_pkg.sv
// Shared constants and helpers for the IFU instruction aligner.
// Mirrors the e203_defines.v values; no new types are introduced.
package e203_ifu_instr_aligner_pkg;

   localparam int          E203_PC_SIZE    = 32;
   localparam int          E203_INSTR_SIZE = 32;
   localparam logic [31:0] E203_RESET_PC   = 32'h8000_0000;

   // A halfword starts a 32-bit instruction when its low two bits are 2'b11.
   function automatic logic is_rv32(input logic [15:0] hw);
      return (hw[1:0] == 2'b11);
   endfunction

endpackage

// File: rtl/e203_ifu_hwq.sv
// Halfword queue: pop 1/2 from the head, then append a fetch word (or only its
// upper half when i_drop_lo) after the surviving entries in the same cycle.
module e203_ifu_hwq #(
   parameter int DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_push,
   input  logic        i_drop_lo,
   input  logic [31:0] i_word,
   input  logic        i_err,
   input  logic        i_pop1,
   input  logic        i_pop2,
   output logic [15:0] o_hw0,
   output logic [15:0] o_hw1,
   output logic        o_err0,
   output logic        o_err1,
   output logic [1:0]  o_cnt
);

   logic [15:0] r_hw [0:2];
   logic [2:0]  r_err;
   logic [1:0]  r_cnt;

   logic [15:0] w_hw [0:2];
   logic [2:0]  w_err;
   logic [1:0]  w_base;
   logic [1:0]  w_cnt;

   always_comb begin
      w_hw[0] = r_hw[0];
      w_hw[1] = r_hw[1];
      w_hw[2] = r_hw[2];
      w_err   = r_err;
      w_base  = r_cnt;
      if (i_pop2) begin
         w_hw[0] = r_hw[2];
         w_err   = {2'b00, r_err[2]};
         w_base  = r_cnt - 2'd2;
      end else if (i_pop1) begin
         w_hw[0] = r_hw[1];
         w_hw[1] = r_hw[2];
         w_err   = {1'b0, r_err[2:1]};
         w_base  = r_cnt - 2'd1;
      end
      w_cnt = w_base;
      if (i_push) begin
         if (i_drop_lo) begin
            case (w_base)
               2'd0:    begin w_hw[0] = i_word[31:16]; w_err[0] = i_err; end
               2'd1:    begin w_hw[1] = i_word[31:16]; w_err[1] = i_err; end
               default: begin w_hw[2] = i_word[31:16]; w_err[2] = i_err; end
            endcase
            w_cnt = w_base + 2'd1;
         end else begin
            case (w_base)
               2'd0: begin
                  w_hw[0] = i_word[15:0];
                  w_hw[1] = i_word[31:16];
                  w_err[0] = i_err;
                  w_err[1] = i_err;
               end
               default: begin
                  w_hw[1] = i_word[15:0];
                  w_hw[2] = i_word[31:16];
                  w_err[1] = i_err;
                  w_err[2] = i_err;
               end
            endcase
            w_cnt = w_base + 2'd2;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) r_hw[i] <= 16'h0;
         r_err <= 3'b000;
         r_cnt <= 2'd0;
      end else if (i_clear) begin
         r_cnt <= 2'd0;
      end else begin
         // Entries at or beyond DEPTH are held at zero so they fold away.
         for (int i = 0; i < 3; i++) r_hw[i] <= (i < DEPTH) ? w_hw[i] : 16'h0;
         r_err <= w_err & ((DEPTH > 2) ? 3'b111 : 3'b011);
         r_cnt <= w_cnt;
      end
   end

   assign o_hw0  = r_hw[0];
   assign o_hw1  = r_hw[1];
   assign o_err0 = r_err[0];
   assign o_err1 = r_err[1];
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/e203_ifu_instr_aligner.sv
// Splits IFU fetch words into whole 16/32-bit instructions for the decoder.
// E203_ALIGNER_RVC_EN enables 16-bit support; undefined builds are 32-bit only.
module e203_ifu_instr_aligner
   import e203_ifu_instr_aligner_pkg::*;
#(
   parameter int                 PC_SIZE  = E203_PC_SIZE,
   parameter logic [PC_SIZE-1:0] RESET_PC = PC_SIZE'(E203_RESET_PC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [PC_SIZE-1:0] flush_pc,
   input  logic               ifu_rsp_valid,
   output logic               ifu_rsp_ready,
   input  logic [31:0]        ifu_rsp_instr,
   input  logic               ifu_rsp_err,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [31:0]        o_instr,
   output logic [PC_SIZE-1:0] o_pc,
   output logic               o_rv32,
   output logic               o_misalgn,
   output logic               o_buserr
);

`ifdef E203_ALIGNER_RVC_EN
   localparam int QDEPTH = 3;
`else
   localparam int QDEPTH = 2;
`endif

   logic [15:0]        w_hw0, w_hw1;
   logic               w_err0, w_err1;
   logic [1:0]         w_cnt;
   logic [PC_SIZE-1:0] r_pc;
   logic               r_mis;
   logic               r_halt;
   logic               w_take2;
   logic               w_avail;
   logic               w_valid;
   logic               w_fire;
   logic               w_pop1, w_pop2;
   logic               w_ready;
   logic               w_push;
   logic               w_drop;
`ifdef E203_ALIGNER_RVC_EN
   logic               r_drop_lo;
`endif

   // w_take2: the head issue consumes two halfwords (an err head always goes alone).
   always_comb begin
`ifdef E203_ALIGNER_RVC_EN
      w_take2 = is_rv32(w_hw0) & ~w_err0;
      w_avail = (w_cnt >= (is_rv32(w_hw0) ? 2'd2 : 2'd1)) | ((w_cnt != 2'd0) & w_err0);
      w_drop  = r_drop_lo;
`else
      w_take2 = 1'b1;
      w_avail = (w_cnt >= 2'd2);
      w_drop  = 1'b0;
`endif
      w_valid = ~flush & (r_mis | (~r_halt & w_avail));
      w_fire  = w_valid & o_ready;
      w_pop2  = w_fire & ~r_mis & w_take2;
      w_pop1  = w_fire & ~r_mis & ~w_take2;
`ifdef E203_ALIGNER_RVC_EN
      w_ready = ~r_mis & ~r_halt & ~flush & ((w_cnt <= 2'd1) | w_pop2);
`else
      w_ready = ~r_mis & ~r_halt & ~flush & ((w_cnt == 2'd0) | w_pop2);
`endif
      w_push  = ifu_rsp_valid & w_ready;
   end

   e203_ifu_hwq #(.DEPTH(QDEPTH)) u_hwq (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (flush),
      .i_push    (w_push),
      .i_drop_lo (w_drop),
      .i_word    (ifu_rsp_instr),
      .i_err     (ifu_rsp_err),
      .i_pop1    (w_pop1),
      .i_pop2    (w_pop2),
      .o_hw0     (w_hw0),
      .o_hw1     (w_hw1),
      .o_err0    (w_err0),
      .o_err1    (w_err1),
      .o_cnt     (w_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc   <= RESET_PC;
         r_mis  <= 1'b0;
         r_halt <= 1'b0;
      end else if (flush) begin
         r_pc   <= flush_pc;
         r_halt <= 1'b0;
`ifdef E203_ALIGNER_RVC_EN
         r_mis  <= flush_pc[0];
`else
         r_mis  <= flush_pc[1] | flush_pc[0];
`endif
      end else begin
         // A consumed misaligned issue parks the aligner until the next redirect.
         if (w_fire & r_mis) begin
            r_mis  <= 1'b0;
            r_halt <= 1'b1;
         end
         if (w_pop2)      r_pc <= r_pc + PC_SIZE'(4);
         else if (w_pop1) r_pc <= r_pc + PC_SIZE'(2);
      end
   end

`ifdef E203_ALIGNER_RVC_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_drop_lo <= RESET_PC[1];
      else if (flush)  r_drop_lo <= flush_pc[1];
      else if (w_push) r_drop_lo <= 1'b0;
   end
`endif

   always_comb begin
      ifu_rsp_ready = w_ready;
      o_valid       = w_valid;
      o_pc          = w_valid ? r_pc : '0;
      o_misalgn     = w_valid & r_mis;
      o_instr       = 32'h0;
      o_buserr      = 1'b0;
      if (w_valid & ~r_mis) begin
         o_instr  = w_take2 ? {w_hw1, w_hw0} : {16'h0, w_hw0};
         o_buserr = w_take2 ? (w_err0 | w_err1) : w_err0;
      end
`ifdef E203_ALIGNER_RVC_EN
      o_rv32 = w_valid & ~r_mis & w_take2;
`else
      o_rv32 = 1'b1;
`endif
   end

endmodule

// File: tb/tb_e203_ifu_instr_aligner.sv
// Directed bench for e203_ifu_instr_aligner with an issue scoreboard.
// Expectations follow E203_ALIGNER_RVC_EN when it is defined for the build.
module tb_e203_ifu_instr_aligner;

   localparam int W = 67;

`ifdef E203_ALIGNER_RVC_EN
   localparam logic RV_IDLE = 1'b0;
`else
   localparam logic RV_IDLE = 1'b1;
`endif

   logic        clk;
   logic        rst;
   logic        flush;
   logic [31:0] flush_pc;
   logic        ifu_rsp_valid;
   logic        ifu_rsp_ready;
   logic [31:0] ifu_rsp_instr;
   logic        ifu_rsp_err;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_rv32;
   logic        o_misalgn;
   logic        o_buserr;

   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   e203_ifu_instr_aligner dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_ready (ifu_rsp_ready),
      .ifu_rsp_instr (ifu_rsp_instr),
      .ifu_rsp_err   (ifu_rsp_err),
      .o_valid       (o_valid),
      .o_ready       (o_ready),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .o_rv32        (o_rv32),
      .o_misalgn     (o_misalgn),
      .o_buserr      (o_buserr)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] cur_obs();
      return {o_instr, o_pc, o_rv32, o_misalgn, o_buserr};
   endfunction

   function automatic logic [W-1:0] mk(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic rv32, input logic mis, input logic berr);
      return {instr, pc, rv32, mis, berr};
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every handshake pops one expected issue
   always @(negedge clk) begin
      if (!rst && o_valid && o_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_issue", cur_obs(), '0);
         end else begin
            chk("issue", cur_obs(), exp_q.pop_front());
         end
      end
   end

   // Driver tasks
   task automatic push_word(input logic [31:0] w, input logic e);
      int n;
      n = 0;
      @(posedge clk); #1;
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = w;
      ifu_rsp_err   = e;
      @(negedge clk);
      while (!ifu_rsp_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("push_accept", (n < 50), 1'b1);
      @(posedge clk); #1;
      ifu_rsp_valid = 1'b0;
      ifu_rsp_err   = 1'b0;
   endtask

   task automatic do_flush(input logic [31:0] pc);
      @(posedge clk); #1;
      flush    = 1'b1;
      flush_pc = pc;
      #1;
      chk("flush_valid", o_valid, 1'b0);
      chk("flush_ready", ifu_rsp_ready, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk(tag, (n < 100), 1'b1);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      flush_pc = 32'h0;
      ifu_rsp_valid = 1'b0;
      ifu_rsp_instr = 32'h0;
      ifu_rsp_err = 1'b0;
      o_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_outputs", cur_obs(), mk(32'h0, 32'h0, RV_IDLE, 1'b0, 1'b0));
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_ready", ifu_rsp_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post_rst_ready", ifu_rsp_ready, 1'b1);

      // 1: single 32-bit word, one-cycle latency
      exp_q.push_back(mk(32'h0000_0513, 32'h8000_0000, 1'b1, 1'b0, 1'b0));
      push_word(32'h0000_0513, 1'b0);
      chk("t1_latency", o_valid, 1'b1);
      drain("t1_drain");

      // 2: two compressed instructions in one word
      do_reset();
`ifdef E203_ALIGNER_RVC_EN
      exp_q.push_back(mk(32'h0000_4501, 32'h8000_0000, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(32'h0000_4501, 32'h8000_0002, 1'b0, 1'b0, 1'b0));
`else
      exp_q.push_back(mk(32'h4501_4501, 32'h8000_0000, 1'b1, 1'b0, 1'b0));
`endif
      push_word(32'h4501_4501, 1'b0);
      drain("t2_drain");

      // 3: 32-bit instruction straddling two words
      do_reset();
`ifdef E203_ALIGNER_RVC_EN
      exp_q.push_back(mk(32'h0000_4501, 32'h8000_0000, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(32'h0000_0513, 32'h8000_0002, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(32'h0000_0001, 32'h8000_0006, 1'b0, 1'b0, 1'b0));
`else
      exp_q.push_back(mk(32'h0513_4501, 32'h8000_0000, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(32'h0001_0000, 32'h8000_0004, 1'b1, 1'b0, 1'b0));
`endif
      push_word(32'h0513_4501, 1'b0);
      push_word(32'h0001_0000, 1'b0);
      drain("t3_drain");

      // 4: flush discards a pending instruction, then redirect to an odd halfword
      o_ready = 1'b0;
      push_word(32'h0000_0513, 1'b0);
      do_flush(32'h8000_0102);
      o_ready = 1'b1;
`ifdef E203_ALIGNER_RVC_EN
      exp_q.push_back(mk(32'h0000_4501, 32'h8000_0102, 1'b0, 1'b0, 1'b0));
      push_word(32'h4501_ABCD, 1'b0);
      drain("t4_drain");
      repeat (2) @(posedge clk);
      #1;
      chk("t4_no_extra", o_valid, 1'b0);
`else
      exp_q.push_back(mk(32'h0, 32'h8000_0102, 1'b1, 1'b1, 1'b0));
      drain("t4_drain");
      chk("t4_stall_ready", ifu_rsp_ready, 1'b0);
`endif

      // 5: odd-byte redirect issues one misaligned marker, then stalls
      do_flush(32'h8000_0101);
      exp_q.push_back(mk(32'h0, 32'h8000_0101, RV_IDLE, 1'b1, 1'b0));
      drain("t5_drain");
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = 32'h0000_0513;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_stall_ready", ifu_rsp_ready, 1'b0);
         chk("t5_stall_valid", o_valid, 1'b0);
      end
      @(posedge clk); #1;
      ifu_rsp_valid = 1'b0;

      // 6: bus-error word held by backpressure, then async reset mid-hold
      do_flush(32'h8000_0200);
      o_ready = 1'b0;
`ifdef E203_ALIGNER_RVC_EN
      exp_q.push_back(mk(32'h0000_0513, 32'h8000_0200, 1'b0, 1'b0, 1'b1));
`else
      exp_q.push_back(mk(32'h0000_0513, 32'h8000_0200, 1'b1, 1'b0, 1'b1));
`endif
      push_word(32'h0000_0513, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t6_hold_valid", o_valid, 1'b1);
         chk("t6_hold", cur_obs(), exp_q[0]);
      end
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", o_valid, 1'b0);
      chk("t6_rst_cnt", dut.w_cnt, 2'd0);
      chk("t6_rst_ready", ifu_rsp_ready, 1'b1);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      o_ready = 1'b1;

      // Restart from the reset PC
      exp_q.push_back(mk(32'h0000_0513, 32'h8000_0000, 1'b1, 1'b0, 1'b0));
      push_word(32'h0000_0513, 1'b0);
      drain("final_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
